pc_sequencer: RTL and testbench

- Parametrised program-counter unit for the single-cycle processor; successor to the plain load-only PC register.
- Each clock, selects the next instruction address from one of five sources:
  - sequential increment
  - signed relative branch
  - absolute jump
  - call, which pushes the return address onto an internal stack
  - return, which pops the stack
- Adds stall, a hardware return-address stack with full/empty status, and sticky overflow/underflow error flags.
- Feeds the instruction-memory address bus and the branch/link logic of the datapath.

---
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, relative branch, absolute jump, and
// call/return through a small hardware return-address stack. Updates on the falling edge.
module pc_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int OFF_W       = 7,
  parameter int STEP        = 1,
  parameter int RESET_ADDR  = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        modo,
  input  logic [OFF_W-1:0]  incremento,
  input  logic [ADDR_W-1:0] destino,
  output logic [ADDR_W-1:0] saida_pc,
  output logic [ADDR_W-1:0] pc_seq,
  output logic              pilha_cheia,
  output logic              pilha_vazia,
  output logic              erro_overflow,
  output logic              erro_underflow
);

  localparam int PTR_W = $clog2(STACK_DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    MODO_INC  = 3'b000,
    MODO_REL  = 3'b001,
    MODO_JMP  = 3'b010,
    MODO_CALL = 3'b011,
    MODO_RET  = 3'b100
  } modo_e;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push;
  logic [ADDR_W-1:0] off_ext;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  top_idx;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  assign off_ext  = ADDR_W'($signed(incremento));
  assign push_idx = ptr_q[IDX_W-1:0];
  // When full, the low index bits wrap to 0, so subtracting 1 still lands on the top entry.
  assign top_idx  = ptr_q[IDX_W-1:0] - IDX_W'(1);

  assign saida_pc       = pc_q;
  assign pc_seq         = pc_q + ADDR_W'(STEP);
  assign pilha_cheia    = (ptr_q == FULL_PTR);
  assign pilha_vazia    = (ptr_q == '0);
  assign erro_overflow  = ovf_q;
  assign erro_underflow = unf_q;

  always_comb begin
    pc_d  = pc_q;
    ptr_d = ptr_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (enable) begin
      case (modo)
        MODO_REL: pc_d = pc_q + off_ext;
        MODO_JMP: pc_d = destino;
        MODO_CALL: begin
          pc_d = destino;
          if (!pilha_cheia) begin
            push  = 1'b1;
            ptr_d = ptr_q + PTR_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        MODO_RET: begin
          if (!pilha_vazia) begin
            pc_d  = stack_q[top_idx];
            ptr_d = ptr_q - PTR_W'(1);
          end else begin
            pc_d  = pc_seq;
            unf_d = 1'b1;
          end
        end
        default: pc_d = pc_seq;
      endcase
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      pc_q  <= ADDR_W'(RESET_ADDR);
      ptr_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage carries no reset; its contents are meaningless while the pointer is 0.
  always_ff @(negedge clock) begin
    if (!reset && push) begin
      stack_q[push_idx] <= pc_seq;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: inputs change 1 time unit after each falling edge,
// and outputs are sampled at that same point, well away from the next active edge.
module tb_pc_sequencer;

  logic       clock = 1'b1;
  logic       reset;
  logic       enable;
  logic [2:0] modo;
  logic [6:0] incremento;
  logic [7:0] destino;
  logic [7:0] saida_pc;
  logic [7:0] pc_seq;
  logic       pilha_cheia, pilha_vazia, erro_overflow, erro_underflow;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.ADDR_W(8), .OFF_W(7), .STEP(1), .RESET_ADDR(0), .STACK_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .enable(enable), .modo(modo),
    .incremento(incremento), .destino(destino), .saida_pc(saida_pc), .pc_seq(pc_seq),
    .pilha_cheia(pilha_cheia), .pilha_vazia(pilha_vazia),
    .erro_overflow(erro_overflow), .erro_underflow(erro_underflow)
  );

  always #5 clock = ~clock;

  task automatic edge_step();
    @(negedge clock);
    #1;
    $display("t=%0t rst=%0b en=%0b modo=%0d inc=%0d dst=%0d -> pc=%0d seq=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
             $time, reset, enable, modo, $signed(incremento), destino, saida_pc, pc_seq,
             pilha_cheia, pilha_vazia, erro_overflow, erro_underflow);
  endtask

  task automatic apply(input logic [2:0] m, input logic [6:0] inc, input logic [7:0] dst);
    reset = 1'b0; enable = 1'b1; modo = m; incremento = inc; destino = dst;
    edge_step();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; modo = 3'b010; incremento = '0; destino = 8'd55;
    edge_step();
    edge_step();
    checks++; if (saida_pc !== 8'd0) begin errors++; $display("FAIL reset_pc got %0d exp 0", saida_pc); end
    checks++; if (pc_seq !== 8'd1) begin errors++; $display("FAIL reset_pc_seq got %0d exp 1", pc_seq); end
    checks++; if (pilha_vazia !== 1'b1 || pilha_cheia !== 1'b0) begin errors++; $display("FAIL reset_stack got empty=%0b full=%0b exp 1/0", pilha_vazia, pilha_cheia); end
    checks++; if (erro_overflow !== 1'b0 || erro_underflow !== 1'b0) begin errors++; $display("FAIL reset_flags got %0b/%0b exp 0/0", erro_overflow, erro_underflow); end
  endtask

  task automatic test_increment();
    for (int i = 1; i <= 3; i++) begin
      apply(3'b000, '0, '0);
      checks++; if (saida_pc !== 8'(i)) begin errors++; $display("FAIL inc_step%0d got %0d exp %0d", i, saida_pc, i); end
    end
    checks++; if (pilha_vazia !== 1'b1 || erro_overflow !== 1'b0 || erro_underflow !== 1'b0) begin errors++; $display("FAIL inc_status got empty=%0b ovf=%0b unf=%0b exp 1/0/0", pilha_vazia, erro_overflow, erro_underflow); end
    // Undefined codes behave as increment and leave the stack alone.
    apply(3'b111, 7'd20, 8'd200);
    checks++; if (saida_pc !== 8'd4 || pilha_vazia !== 1'b1) begin errors++; $display("FAIL undef_modo got pc=%0d empty=%0b exp 4/1", saida_pc, pilha_vazia); end
  endtask

  task automatic test_branch();
    apply(3'b010, '0, 8'd10);
    checks++; if (saida_pc !== 8'd10) begin errors++; $display("FAIL jump got %0d exp 10", saida_pc); end
    apply(3'b001, 7'b1111101, '0);
    checks++; if (saida_pc !== 8'd7) begin errors++; $display("FAIL branch_neg got %0d exp 7", saida_pc); end
    apply(3'b001, 7'b0000101, '0);
    checks++; if (saida_pc !== 8'd12) begin errors++; $display("FAIL branch_pos got %0d exp 12", saida_pc); end
    apply(3'b010, '0, 8'd254);
    apply(3'b001, 7'd5, '0);
    checks++; if (saida_pc !== 8'd3) begin errors++; $display("FAIL branch_wrap got %0d exp 3", saida_pc); end
  endtask

  task automatic test_nested_calls();
    apply(3'b010, '0, 8'd5);
    apply(3'b011, '0, 8'd40);
    checks++; if (saida_pc !== 8'd40 || pilha_vazia !== 1'b0) begin errors++; $display("FAIL call1 got pc=%0d empty=%0b exp 40/0", saida_pc, pilha_vazia); end
    apply(3'b011, '0, 8'd80);
    checks++; if (saida_pc !== 8'd80) begin errors++; $display("FAIL call2 got %0d exp 80", saida_pc); end
    apply(3'b100, '0, '0);
    checks++; if (saida_pc !== 8'd41) begin errors++; $display("FAIL ret1 got %0d exp 41", saida_pc); end
    apply(3'b100, '0, '0);
    checks++; if (saida_pc !== 8'd6 || pilha_vazia !== 1'b1) begin errors++; $display("FAIL ret2 got pc=%0d empty=%0b exp 6/1", saida_pc, pilha_vazia); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_ret [4];
    exp_ret = '{8'd31, 8'd21, 8'd11, 8'd101};
    apply(3'b010, '0, 8'd100);
    apply(3'b011, '0, 8'd10);
    apply(3'b011, '0, 8'd20);
    apply(3'b011, '0, 8'd30);
    checks++; if (pilha_cheia !== 1'b0) begin errors++; $display("FAIL three_calls_full got %0b exp 0", pilha_cheia); end
    apply(3'b011, '0, 8'd40);
    checks++; if (pilha_cheia !== 1'b1 || erro_overflow !== 1'b0) begin errors++; $display("FAIL four_calls got full=%0b ovf=%0b exp 1/0", pilha_cheia, erro_overflow); end
    apply(3'b011, '0, 8'd99);
    checks++; if (saida_pc !== 8'd99 || erro_overflow !== 1'b1 || pilha_cheia !== 1'b1) begin errors++; $display("FAIL overflow_call got pc=%0d ovf=%0b full=%0b exp 99/1/1", saida_pc, erro_overflow, pilha_cheia); end
    for (int i = 0; i < 4; i++) begin
      apply(3'b100, '0, '0);
      checks++; if (saida_pc !== exp_ret[i]) begin errors++; $display("FAIL lifo_ret%0d got %0d exp %0d", i, saida_pc, exp_ret[i]); end
    end
    checks++; if (pilha_vazia !== 1'b1 || erro_underflow !== 1'b0) begin errors++; $display("FAIL drained got empty=%0b unf=%0b exp 1/0", pilha_vazia, erro_underflow); end
    apply(3'b100, '0, '0);
    checks++; if (saida_pc !== 8'd102 || erro_underflow !== 1'b1 || erro_overflow !== 1'b1) begin errors++; $display("FAIL underflow got pc=%0d unf=%0b ovf=%0b exp 102/1/1", saida_pc, erro_underflow, erro_overflow); end
  endtask

  task automatic test_stall();
    apply(3'b010, '0, 8'd60);
    apply(3'b011, '0, 8'd20);
    enable = 1'b0; modo = 3'b010; destino = 8'd77;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      checks++; if (saida_pc !== 8'd20 || pc_seq !== 8'd21) begin errors++; $display("FAIL stall%0d got pc=%0d seq=%0d exp 20/21", i, saida_pc, pc_seq); end
    end
    checks++; if (pilha_vazia !== 1'b0 || erro_overflow !== 1'b1 || erro_underflow !== 1'b1) begin errors++; $display("FAIL stall_hold got empty=%0b ovf=%0b unf=%0b exp 0/1/1", pilha_vazia, erro_overflow, erro_underflow); end
    apply(3'b010, '0, 8'd77);
    checks++; if (saida_pc !== 8'd77) begin errors++; $display("FAIL stall_release got %0d exp 77", saida_pc); end
    apply(3'b100, '0, '0);
    checks++; if (saida_pc !== 8'd61 || pilha_vazia !== 1'b1) begin errors++; $display("FAIL stall_stack got pc=%0d empty=%0b exp 61/1", saida_pc, pilha_vazia); end
  endtask

  task automatic test_reset_mid();
    apply(3'b011, '0, 8'd150);
    reset = 1'b1; enable = 1'b0; modo = 3'b100;
    edge_step();
    checks++; if (saida_pc !== 8'd0 || pilha_vazia !== 1'b1) begin errors++; $display("FAIL mid_reset got pc=%0d empty=%0b exp 0/1", saida_pc, pilha_vazia); end
    checks++; if (erro_overflow !== 1'b0 || erro_underflow !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got %0b/%0b exp 0/0", erro_overflow, erro_underflow); end
    apply(3'b100, '0, '0);
    checks++; if (saida_pc !== 8'd1 || erro_underflow !== 1'b1) begin errors++; $display("FAIL post_reset_ret got pc=%0d unf=%0b exp 1/1", saida_pc, erro_underflow); end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_branch();
    test_nested_calls();
    test_overflow();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
